// File: rtl/lock_pkg.sv
// Shared types for the combination lock: state encoding, default sizes and the
// one-hot status flag decode used by both the sequencer and the hex status display.
package lock_pkg;

  localparam int unsigned CODE_LEN_DEF      = 4;
  localparam int unsigned DIGIT_W_DEF       = 4;
  localparam int unsigned MAX_FAIL_DEF      = 3;
  localparam int unsigned ALARM_CYCLES_DEF  = 50;
  localparam int unsigned RELOCK_CYCLES_DEF = 100;
  localparam int unsigned FAIL_W            = 2;
  localparam int unsigned DCNT_W            = 3;

  typedef enum logic [2:0] {
    LOCKED  = 3'd0,
    ENTRY   = 3'd1,
    OPEN    = 3'd2,
    PROGRAM = 3'd3,
    ALARM   = 3'd4
  } state_t;

  typedef struct packed {
    logic new_code;
    logic open;
    logic alarm;
  } flags_t;

  localparam flags_t FLAGS_NONE  = 3'b000;
  localparam flags_t FLAGS_NEW   = 3'b100;
  localparam flags_t FLAGS_OPEN  = 3'b010;
  localparam flags_t FLAGS_ALARM = 3'b001;

  function automatic flags_t decode_flags(input state_t s);
    case (s)
      PROGRAM: return FLAGS_NEW;
      OPEN:    return FLAGS_OPEN;
      ALARM:   return FLAGS_ALARM;
      default: return FLAGS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that saturates at zero; shared by the alarm hold and
// the optional relock timeout.
module lock_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Combination lock sequencer: digit entry, code compare, fail counting, alarm hold
// and code reprogramming. Define LOCK_AUTO_RELOCK_EN to relock OPEN after an idle timeout.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned CODE_LEN      = CODE_LEN_DEF,
  parameter int unsigned DIGIT_W       = DIGIT_W_DEF,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int unsigned MAX_FAIL      = MAX_FAIL_DEF,
  parameter int unsigned ALARM_CYCLES  = ALARM_CYCLES_DEF,
  parameter int unsigned RELOCK_CYCLES = RELOCK_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic               enter,
  input  logic               clear,
  input  logic               set_code,
  output logic               new_code,
  output logic               open,
  output logic               alarm,
  output logic [FAIL_W-1:0]  fail_count,
  output logic [DCNT_W-1:0]  digit_count
);

  localparam int unsigned CODE_W   = CODE_LEN * DIGIT_W;
  localparam int unsigned HOLD_MAX = (ALARM_CYCLES > RELOCK_CYCLES) ? ALARM_CYCLES : RELOCK_CYCLES;
  localparam int unsigned TIMER_W  = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
`ifdef LOCK_AUTO_RELOCK_EN
  localparam bit RELOCK_EN = 1'b1;
`else
  localparam bit RELOCK_EN = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   buf_q, buf_d, buf_store;
  logic [DCNT_W-1:0]   cnt_q, cnt_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  flags_t              flags_q;
  logic                alarm_load, relock_load, timer_load, timer_zero_c;
  logic [TIMER_W-1:0]  timer_val;
  logic                full, match;

  assign full  = (cnt_q == DCNT_W'(CODE_LEN));
  assign match = full && (buf_q == code_q);

  // Entry buffer with the incoming digit written into slot cnt_q (digit 0 in MSBs)
  always_comb begin
    buf_store = buf_q;
    for (int i = 0; i < int'(CODE_LEN); i++) begin
      if (cnt_q == DCNT_W'(i)) buf_store[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    fail_d      = fail_q;
    alarm_load  = 1'b0;
    relock_load = 1'b0;
    case (state_q)
      LOCKED: begin
        if (!clear && !enter && digit_valid) begin
          buf_d   = buf_store;
          cnt_d   = DCNT_W'(1);
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (clear) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = LOCKED;
        end else if (enter) begin
          buf_d = '0;
          cnt_d = '0;
          if (match) begin
            fail_d      = '0;
            state_d     = OPEN;
            relock_load = 1'b1;
          end else begin
            fail_d = fail_q + FAIL_W'(1);
            if (32'(fail_q) + 32'd1 >= MAX_FAIL) begin
              state_d    = ALARM;
              alarm_load = 1'b1;
            end else begin
              state_d = LOCKED;
            end
          end
        end else if (digit_valid && !full) begin
          buf_d = buf_store;
          cnt_d = cnt_q + DCNT_W'(1);
        end
      end
      OPEN: begin
        // clear has no meaning here, so a clear cycle behaves as an idle cycle
        if (!clear && enter) begin
          state_d = LOCKED;
        end else if (!clear && set_code) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = PROGRAM;
        end else if (!clear && digit_valid) begin
          relock_load = 1'b1;
        end else if (RELOCK_EN && timer_zero_c) begin
          state_d = LOCKED;
        end
      end
      PROGRAM: begin
        if (clear) begin
          buf_d       = '0;
          cnt_d       = '0;
          state_d     = OPEN;
          relock_load = 1'b1;
        end else if (enter) begin
          buf_d = '0;
          cnt_d = '0;
          if (full) begin
            code_d  = buf_q;
            state_d = LOCKED;
          end
        end else if (digit_valid && !full) begin
          buf_d = buf_store;
          cnt_d = cnt_q + DCNT_W'(1);
        end
      end
      ALARM: begin
        if (timer_zero_c) begin
          fail_d  = '0;
          state_d = LOCKED;
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  assign timer_load = alarm_load || (RELOCK_EN && relock_load);
  assign timer_val  = alarm_load ? TIMER_W'(ALARM_CYCLES - 1) : TIMER_W'(RELOCK_CYCLES - 1);

  lock_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (timer_load),
    .load_val (timer_val),
    .zero_c   (timer_zero_c)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= LOCKED;
      code_q  <= DEFAULT_CODE;
      buf_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      flags_q <= FLAGS_NONE;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      flags_q <= decode_flags(state_d);
    end
  end

  assign new_code    = flags_q.new_code;
  assign open        = flags_q.open;
  assign alarm       = flags_q.alarm;
  assign fail_count  = fail_q;
  assign digit_count = cnt_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: directed scenarios plus random strobes
// compared against a digit-queue model of the lock.
module tb_lock_sequencer;

  localparam int LEN        = 4;
  localparam int MAXF       = 3;
  localparam int ALARM_HOLD = 50;
  localparam int RELOCK     = 100;
`ifdef LOCK_AUTO_RELOCK_EN
  localparam bit RELOCK_ON = 1'b1;
`else
  localparam bit RELOCK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] digit_in;
  logic       digit_valid, enter, clear, set_code;
  logic       new_code, open, alarm;
  logic [1:0] fail_count;
  logic [2:0] digit_count;
  logic [7:0] obs;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lock_sequencer dut (
    .clk         (clk),
    .resetn      (resetn),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .enter       (enter),
    .clear       (clear),
    .set_code    (set_code),
    .new_code    (new_code),
    .open        (open),
    .alarm       (alarm),
    .fail_count  (fail_count),
    .digit_count (digit_count)
  );

  assign obs = {new_code, open, alarm, fail_count, digit_count};

  // Model: typed digits in a queue, the code as a digit array, mode bits and counters
  logic [3:0] m_code [LEN];
  logic [3:0] m_q [$];
  bit         m_open, m_prog, m_alarm;
  int         m_fails, m_alarm_left, m_idle;

  function automatic void model_reset();
    m_code  = '{4'd1, 4'd2, 4'd3, 4'd4};
    m_q.delete();
    m_open  = 0;
    m_prog  = 0;
    m_alarm = 0;
    m_fails = 0;
    m_alarm_left = 0;
    m_idle  = 0;
  endfunction

  function automatic void model_step(input bit dv, input logic [3:0] d, input bit en,
                                     input bit clr, input bit sc);
    bit match;
    if (m_alarm) begin
      m_alarm_left--;
      if (m_alarm_left == 0) begin
        m_alarm = 0;
        m_fails = 0;
      end
    end else if (m_prog) begin
      if (clr) begin
        m_prog = 0;
        m_open = 1;
        m_idle = 0;
        m_q.delete();
      end else if (en) begin
        if (m_q.size() == LEN) begin
          for (int i = 0; i < LEN; i++) m_code[i] = m_q[i];
          m_prog = 0;
        end
        m_q.delete();
      end else if (dv && m_q.size() < LEN) begin
        m_q.push_back(d);
      end
    end else if (m_open) begin
      if (!clr && en) begin
        m_open = 0;
      end else if (!clr && sc) begin
        m_open = 0;
        m_prog = 1;
        m_q.delete();
      end else if (RELOCK_ON) begin
        if (!clr && dv) m_idle = 0;
        else if (m_idle == RELOCK - 1) m_open = 0;
        else m_idle++;
      end
    end else if (m_q.size() == 0) begin
      if (!clr && !en && dv) m_q.push_back(d);
    end else begin
      if (clr) begin
        m_q.delete();
      end else if (en) begin
        match = (m_q.size() == LEN);
        if (match) for (int i = 0; i < LEN; i++) if (m_q[i] !== m_code[i]) match = 0;
        m_q.delete();
        if (match) begin
          m_fails = 0;
          m_open  = 1;
          m_idle  = 0;
        end else begin
          m_fails++;
          if (m_fails >= MAXF) begin
            m_alarm = 1;
            m_alarm_left = ALARM_HOLD;
          end
        end
      end else if (dv && m_q.size() < LEN) begin
        m_q.push_back(d);
      end
    end
  endfunction

  function automatic logic [7:0] exp_vec();
    return {m_prog, m_open, m_alarm, 2'(m_fails), 3'(m_q.size())};
  endfunction

  task automatic tick(input bit dv, input logic [3:0] d, input bit en, input bit clr, input bit sc);
    digit_valid = dv;
    digit_in    = d;
    enter       = en;
    clear       = clr;
    set_code    = sc;
    @(posedge clk);
    model_step(dv, d, en, clr, sc);
    #1;
    digit_valid = 0;
    digit_in    = '0;
    enter       = 0;
    clear       = 0;
    set_code    = 0;
  endtask

  task automatic type_digits(input logic [15:0] code, input int n);
    for (int i = 0; i < n; i++) tick(1, code[15-4*i -: 4], 0, 0, 0);
  endtask

  task automatic test_reset();
    resetn = 0;
    digit_valid = 0; digit_in = '0; enter = 0; clear = 0; set_code = 0;
    model_reset();
    #12;
    n_chk++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state got %b expected %b", obs, 8'h00);
    end
    resetn = 1;
    tick(0, 0, 0, 0, 0);
    n_chk++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_idle got %b expected %b", obs, exp_vec());
    end
  endtask

  task automatic test_open();
    for (int i = 0; i < LEN; i++) begin
      tick(1, 4'(i + 1), 0, 0, 0);
      n_chk++;
      if (digit_count !== 3'(i + 1)) begin
        n_fail++;
        $display("FAIL open_digit_count got %0d expected %0d", digit_count, i + 1);
      end
    end
    tick(0, 0, 1, 0, 0);
    n_chk++;
    if (open !== 1'b1 || fail_count !== 2'd0 || digit_count !== 3'd0) begin
      n_fail++;
      $display("FAIL open_after_enter got open=%b fail=%0d cnt=%0d expected 1 0 0",
               open, fail_count, digit_count);
    end
    tick(0, 0, 1, 0, 0);
    n_chk++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL open_relock got %b expected %b", obs, exp_vec());
    end
  endtask

  task automatic test_alarm();
    for (int k = 1; k <= 3; k++) begin
      type_digits(16'h1235, 4);
      tick(0, 0, 1, 0, 0);
      n_chk++;
      if (fail_count !== 2'(k) || alarm !== (k == 3)) begin
        n_fail++;
        $display("FAIL alarm_attempt%0d got fail=%0d alarm=%b expected %0d %b",
                 k, fail_count, alarm, k, k == 3);
      end
    end
    for (int c = 1; c < ALARM_HOLD; c++) begin
      tick(1, 4'd1, c == 10, c == 20, c == 30);
      n_chk++;
      if (alarm !== 1'b1 || obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL alarm_hold cycle %0d got %b expected %b", c, obs, exp_vec());
      end
    end
    tick(0, 0, 0, 0, 0);
    n_chk++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL alarm_release got %b expected %b", obs, 8'h00);
    end
  endtask

  task automatic test_program();
    type_digits(16'h1234, 4);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 1);
    n_chk++;
    if (new_code !== 1'b1 || open !== 1'b0 || alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL program_new got new=%b open=%b alarm=%b expected 1 0 0", new_code, open, alarm);
    end
    type_digits(16'h9876, 4);
    n_chk++;
    if (obs !== exp_vec() || new_code !== 1'b1) begin
      n_fail++;
      $display("FAIL program_digits got %b expected %b", obs, exp_vec());
    end
    tick(0, 0, 1, 0, 0);
    n_chk++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL program_commit got %b expected %b", obs, 8'h00);
    end
    type_digits(16'h1234, 4);
    tick(0, 0, 1, 0, 0);
    n_chk++;
    if (open !== 1'b0 || fail_count !== 2'd1) begin
      n_fail++;
      $display("FAIL program_old_code got open=%b fail=%0d expected 0 1", open, fail_count);
    end
    type_digits(16'h9876, 4);
    tick(0, 0, 1, 0, 0);
    n_chk++;
    if (open !== 1'b1 || fail_count !== 2'd0) begin
      n_fail++;
      $display("FAIL program_new_code got open=%b fail=%0d expected 1 0", open, fail_count);
    end
    tick(0, 0, 1, 0, 0);
  endtask

  task automatic test_short_priority();
    type_digits(16'h9800, 2);
    tick(0, 0, 1, 0, 0);
    n_chk++;
    if (fail_count !== 2'd1 || open !== 1'b0 || digit_count !== 3'd0) begin
      n_fail++;
      $display("FAIL short_entry got fail=%0d open=%b cnt=%0d expected 1 0 0",
               fail_count, open, digit_count);
    end
    type_digits(16'h9876, 4);
    tick(1, 4'd5, 1, 0, 0);
    n_chk++;
    if (open !== 1'b1 || digit_count !== 3'd0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL enter_beats_digit got %b expected %b", obs, exp_vec());
    end
    tick(0, 0, 1, 0, 0);
    type_digits(16'h9876, 4);
    tick(1, 4'd5, 0, 0, 0);
    n_chk++;
    if (digit_count !== 3'd4) begin
      n_fail++;
      $display("FAIL fifth_digit_count got %0d expected 4", digit_count);
    end
    tick(0, 0, 1, 0, 0);
    n_chk++;
    if (open !== 1'b1) begin
      n_fail++;
      $display("FAIL fifth_digit_open got %b expected 1", open);
    end
    tick(0, 0, 1, 0, 0);
    type_digits(16'h9800, 2);
    tick(1, 4'd7, 1, 1, 0);
    n_chk++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL clear_priority got %b expected %b", obs, 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      type_digits(16'h1235, 4);
      tick(0, 0, 1, 0, 0);
    end
    repeat (10) tick(0, 0, 0, 0, 0);
    resetn = 0;
    model_reset();
    #1;
    n_chk++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_alarm got %b expected %b", obs, 8'h00);
    end
    resetn = 1;
    type_digits(16'h1234, 4);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 1);
    type_digits(16'h9876, 4);
    tick(0, 0, 1, 0, 0);
    type_digits(16'h9800, 2);
    resetn = 0;
    model_reset();
    #1;
    n_chk++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_entry got %b expected %b", obs, 8'h00);
    end
    resetn = 1;
    type_digits(16'h9876, 4);
    tick(0, 0, 1, 0, 0);
    n_chk++;
    if (open !== 1'b0 || fail_count !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_code_lost got open=%b fail=%0d expected 0 1", open, fail_count);
    end
    type_digits(16'h1234, 4);
    tick(0, 0, 1, 0, 0);
    n_chk++;
    if (open !== 1'b1 || fail_count !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_default_code got open=%b fail=%0d expected 1 0", open, fail_count);
    end
    tick(0, 0, 1, 0, 0);
  endtask

  task automatic test_relock();
    type_digits(16'h1234, 4);
    tick(0, 0, 1, 0, 0);
`ifdef LOCK_AUTO_RELOCK_EN
    repeat (49) tick(0, 0, 0, 0, 0);
    tick(1, 4'd5, 0, 0, 0);
    repeat (RELOCK - 1) tick(0, 0, 0, 0, 0);
    n_chk++;
    if (open !== 1'b1) begin
      n_fail++;
      $display("FAIL relock_restart got open=%b expected 1", open);
    end
    tick(0, 0, 0, 0, 0);
    n_chk++;
    if (open !== 1'b0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL relock_timeout got %b expected %b", obs, exp_vec());
    end
`else
    repeat (500) tick(0, 0, 0, 0, 0);
    n_chk++;
    if (open !== 1'b1 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL open_hold got %b expected %b", obs, exp_vec());
    end
    tick(0, 0, 1, 0, 0);
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      int r;
      bit dv, en, clr, sc;
      logic [3:0] d;
      r = $urandom_range(0, 99);
      dv = 0; en = 0; clr = 0; sc = 0; d = '0;
      if (r < 4) clr = 1;
      else if (r < 12) en = 1;
      else if (r < 18) sc = 1;
      else if (r < 70) begin
        dv = 1;
        if ($urandom_range(0, 9) < 8 && m_q.size() < LEN && !m_prog) d = m_code[m_q.size()];
        else d = 4'($urandom_range(1, 9));
      end
      tick(dv, d, en, clr, sc);
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random step %0d got %b expected %b", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_alarm();
    test_program();
    test_short_priority();
    test_reset_mid();
    test_relock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
